// File: rtl/systolic_bs_array.sv
// Output-stationary ROWS x COLS systolic array of bit-serial integer MAC PEs.
// Activations enter per row, weight bits enter MSB first per column. Both are
// skewed internally so PE(r,c) sees beat b exactly r+c advancing cycles later.
// The registers only advance on an accepted beat or during FLUSH. Results are
// drained serially in row-major order over a valid/ready handshake.
module systolic_bs_array #(
    parameter int ACT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int MAX_PREC  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                prec,
    input  logic [15:0]               k_len,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*ACT_WIDTH-1:0] act_in,
    input  logic [COLS-1:0]           w_bits,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      out_data,
    output logic [15:0]               out_idx,
    output logic                      done
);

    localparam int NPE       = ROWS * COLS;
    localparam int IDX_W     = (NPE > 1) ? $clog2(NPE) : 1;
    localparam int NPAD      = 1 << IDX_W;
    localparam int FLUSH_LEN = ROWS + COLS - 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t                 state_reg;
    logic [3:0]             prec_reg;
    logic [15:0]            k_len_reg;
    logic [3:0]             bit_cnt_reg;
    logic [15:0]            term_cnt_reg;
    logic [15:0]            flush_cnt_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [ACC_WIDTH-1:0]   out_data_reg;
    logic                   done_reg;

    logic                   accept;
    logic                   adv;
    logic                   clr;
    logic                   msb;
    logic                   lsb;
    logic                   last_beat;
    logic [3:0]             prec_eff;

    // Inputs seen by each PE: activation and {valid, msb, lsb, bit} tag.
    logic [ACT_WIDTH-1:0]   a_h [ROWS][COLS];
    logic [3:0]             t_v [ROWS][COLS];
    // Accumulators flattened row-major, padded to a power of two for indexing.
    logic [ACC_WIDTH-1:0]   acc_pad [NPAD];

    assign accept    = (state_reg == LOAD) && in_valid;
    assign adv       = accept || (state_reg == FLUSH);
    assign clr       = (state_reg == IDLE) && start && !done_reg;
    assign msb       = (bit_cnt_reg == 4'd0);
    assign lsb       = (bit_cnt_reg == prec_reg - 4'd1);
    assign last_beat = accept && lsb && (term_cnt_reg == k_len_reg - 16'd1);
    assign prec_eff  = (prec < 4'd2 || prec > 4'(MAX_PREC)) ? 4'(MAX_PREC) : prec;

    // Row skew: lane r is delayed r advancing stages before entering column 0.
    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row_skew
            if (gi == 0) begin : g_direct
                assign a_h[gi][0] = act_in[gi*ACT_WIDTH +: ACT_WIDTH];
            end else begin : g_delay
                logic [ACT_WIDTH-1:0] sk_reg [gi];
                // Shift the lane's activation one stage per advancing cycle.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int k = 0; k < gi; k++) sk_reg[k] <= '0;
                    end else if (adv) begin
                        sk_reg[0] <= act_in[gi*ACT_WIDTH +: ACT_WIDTH];
                        for (int k = 1; k < gi; k++) sk_reg[k] <= sk_reg[k-1];
                    end
                end
                assign a_h[gi][0] = sk_reg[gi-1];
            end
        end

        // Column skew: tag for column c is delayed c advancing stages before row 0.
        for (gj = 0; gj < COLS; gj++) begin : g_col_skew
            logic [3:0] tag_in;
            assign tag_in = {accept, msb, lsb, w_bits[gj]};
            if (gj == 0) begin : g_direct
                assign t_v[0][gj] = tag_in;
            end else begin : g_delay
                logic [3:0] sk_reg [gj];
                // Shift the column's tag one stage per advancing cycle.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int k = 0; k < gj; k++) sk_reg[k] <= '0;
                    end else if (adv) begin
                        sk_reg[0] <= tag_in;
                        for (int k = 1; k < gj; k++) sk_reg[k] <= sk_reg[k-1];
                    end
                end
                assign t_v[0][gj] = sk_reg[gj-1];
            end
        end

        // PE grid with the pass-through registers feeding right and down.
        for (gi = 0; gi < ROWS; gi++) begin : g_pe_row
            for (gj = 0; gj < COLS; gj++) begin : g_pe_col
                logic signed [ACC_WIDTH-1:0] act_ext;
                logic signed [ACC_WIDTH-1:0] part_reg;
                logic signed [ACC_WIDTH-1:0] part_next;
                logic signed [ACC_WIDTH-1:0] acc_reg;
                logic                        t_valid;
                logic                        t_msb;
                logic                        t_lsb;
                logic                        t_bit;

                assign act_ext = ACC_WIDTH'($signed(a_h[gi][gj]));
                assign {t_valid, t_msb, t_lsb, t_bit} = t_v[gi][gj];

                // MSB carries negative weight; later bits shift-and-add.
                always_comb begin
                    part_next = '0;
                    if (t_msb) begin
                        part_next = t_bit ? -act_ext : '0;
                    end else begin
                        part_next = (part_reg <<< 1) + (t_bit ? act_ext : '0);
                    end
                end

                // Accumulate the finished partial product on the LSB beat.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        part_reg <= '0;
                        acc_reg  <= '0;
                    end else if (clr) begin
                        part_reg <= '0;
                        acc_reg  <= '0;
                    end else if (adv && t_valid) begin
                        part_reg <= part_next;
                        if (t_lsb) acc_reg <= acc_reg + part_next;
                    end
                end

                assign acc_pad[gi*COLS + gj] = acc_reg;

                if (gj < COLS - 1) begin : g_pass_right
                    logic [ACT_WIDTH-1:0] a_reg;
                    // Forward the activation to the next column.
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst)      a_reg <= '0;
                        else if (adv) a_reg <= a_h[gi][gj];
                    end
                    assign a_h[gi][gj+1] = a_reg;
                end

                if (gi < ROWS - 1) begin : g_pass_down
                    logic [3:0] t_reg;
                    // Forward the weight tag to the next row.
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst)      t_reg <= '0;
                        else if (adv) t_reg <= t_v[gi][gj];
                    end
                    assign t_v[gi+1][gj] = t_reg;
                end
            end
        end

        for (gi = NPE; gi < NPAD; gi++) begin : g_pad
            assign acc_pad[gi] = '0;
        end
    endgenerate

    // Job control: latch parameters, count beats and terms, flush, then drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            prec_reg      <= '0;
            k_len_reg     <= '0;
            bit_cnt_reg   <= '0;
            term_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
            idx_reg       <= '0;
            out_data_reg  <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clr) begin
                        prec_reg      <= prec_eff;
                        k_len_reg     <= k_len;
                        bit_cnt_reg   <= '0;
                        term_cnt_reg  <= '0;
                        flush_cnt_reg <= '0;
                        idx_reg       <= '0;
                        out_data_reg  <= '0;
                        state_reg     <= (k_len == 16'd0) ? DRAIN : LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (lsb) begin
                            bit_cnt_reg  <= '0;
                            term_cnt_reg <= term_cnt_reg + 16'd1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                        if (last_beat) state_reg <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_reg == 16'(FLUSH_LEN - 1)) begin
                        state_reg    <= DRAIN;
                        idx_reg      <= '0;
                        out_data_reg <= acc_pad[0];
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + 16'd1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx_reg == IDX_W'(NPE - 1)) begin
                            state_reg    <= IDLE;
                            done_reg     <= 1'b1;
                            idx_reg      <= '0;
                            out_data_reg <= '0;
                        end else begin
                            idx_reg      <= idx_reg + 1'b1;
                            out_data_reg <= acc_pad[idx_reg + 1'b1];
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign in_ready  = (state_reg == LOAD);
    assign out_valid = (state_reg == DRAIN);
    assign out_data  = out_data_reg;
    assign out_idx   = 16'(idx_reg);
    assign done      = done_reg;

endmodule
